// File: rtl/cplx_pkg.sv
// Shared definitions for the complex-number execution unit: opcodes, instruction
// field positions, sequencer states and the 4-bit signed saturation helper.
package cplx_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int unsigned OpHi  = 19;
  localparam int unsigned OpLo  = 18;
  localparam int unsigned Rs1Hi = 17;
  localparam int unsigned Rs1Lo = 12;
  localparam int unsigned Rs2Hi = 11;
  localparam int unsigned Rs2Lo = 6;
  localparam int unsigned RdHi  = 5;
  localparam int unsigned RdLo  = 0;

  typedef enum logic [2:0] {
    StIdle, StRead, StLoad, StExec, StMul, StWrite, StDone
  } state_e;

  // Clamp a widened signed intermediate into a 4-bit signed nibble.
  function automatic logic [3:0] sat4(input logic signed [8:0] v);
    if (v > 9'sd7)  return 4'h7;
    if (v < -9'sd8) return 4'h8;
    return v[3:0];
  endfunction

endpackage

// File: rtl/cplx_mul4.sv
// Combinational 4x4 signed multiplier producing a full-precision 8-bit product.
module cplx_mul4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic signed [7:0] a_ext;
  logic signed [7:0] b_ext;

  // An 8-bit product of two sign-extended nibbles never overflows.
  assign a_ext = {{4{a[3]}}, a};
  assign b_ext = {{4{b[3]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/complex_exec_unit.sv
// Instruction sequencer and complex ALU in front of the 64x8 data memory: reads rs1/rs2,
// computes add/sub/mul on packed {re,im} nibbles with saturation and writes back to rd.
module complex_exec_unit
  import cplx_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [2+3*ADDR_W-1:0] instr,
  output logic                instr_ready,
  output logic                done,
  output logic                err,
  output logic                mem_enable,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_read_address1,
  output logic [ADDR_W-1:0]   mem_read_address2,
  output logic [ADDR_W-1:0]   mem_write_address,
  output logic [DATA_W-1:0]   mem_in_data,
  input  logic [DATA_W-1:0]   mem_out_data1,
  input  logic [DATA_W-1:0]   mem_out_data2
);

  localparam int unsigned InstrW = 2 + 3 * ADDR_W;

  state_e                   state_q, state_d;
  logic [InstrW-1:0]        instr_q, instr_d;
  logic [DATA_W-1:0]        opa_q, opa_d, opb_q, opb_d;
  logic [1:0]               cnt_q, cnt_d;
  logic signed [8:0]        re_acc_q, re_acc_d, im_acc_q, im_acc_d;

  logic                     ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic                     enable_q, enable_d, write_q, write_d;
  logic [ADDR_W-1:0]        ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;

  logic [1:0]               op;
  logic signed [8:0]        a_re, a_im, b_re, b_im, sum_re, sum_im, prod9;
  logic [3:0]               mul_x, mul_y;
  logic [7:0]               prod;

  assign op   = instr_q[OpHi:OpLo];
  assign a_re = {{5{opa_q[7]}}, opa_q[7:4]};
  assign a_im = {{5{opa_q[3]}}, opa_q[3:0]};
  assign b_re = {{5{opb_q[7]}}, opb_q[7:4]};
  assign b_im = {{5{opb_q[3]}}, opb_q[3:0]};

  assign sum_re = (op == OP_SUB) ? a_re - b_re : a_re + b_re;
  assign sum_im = (op == OP_SUB) ? a_im - b_im : a_im + b_im;

  // Multiplier schedule by cycle: 0 -> ac, 1 -> bd, 2 -> ad, 3 -> bc.
  assign mul_x = (cnt_q == 2'd0 || cnt_q == 2'd2) ? opa_q[7:4] : opa_q[3:0];
  assign mul_y = (cnt_q == 2'd0 || cnt_q == 2'd3) ? opb_q[7:4] : opb_q[3:0];
  assign prod9 = {prod[7], prod};

  cplx_mul4 u_mul (
    .a(mul_x),
    .b(mul_y),
    .p(prod)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    re_acc_d = re_acc_q;
    im_acc_d = im_acc_q;
    ra1_d    = '0;
    ra2_d    = '0;
    wa_d     = '0;
    wdata_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          state_d = StRead;
          instr_d = instr;
          ra1_d   = instr[Rs1Hi:Rs1Lo];
          ra2_d   = instr[Rs2Hi:Rs2Lo];
        end
      end
      StRead: state_d = StLoad;
      StLoad: begin
        opa_d    = mem_out_data1;
        opb_d    = mem_out_data2;
        cnt_d    = '0;
        re_acc_d = '0;
        im_acc_d = '0;
        unique case (op)
          OP_ADD, OP_SUB: state_d = StExec;
          OP_MUL:         state_d = StMul;
          default:        state_d = StDone;
        endcase
      end
      StExec: begin
        state_d = StWrite;
        wa_d    = instr_q[RdHi:RdLo];
        wdata_d = {sat4(sum_re), sat4(sum_im)};
      end
      StMul: begin
        cnt_d = cnt_q + 2'd1;
        unique case (cnt_q)
          2'd0: re_acc_d = prod9;
          2'd1: re_acc_d = re_acc_q - prod9;
          2'd2: im_acc_d = prod9;
          default: begin
            state_d = StWrite;
            wa_d    = instr_q[RdHi:RdLo];
            wdata_d = {sat4(re_acc_q), sat4(im_acc_q + prod9)};
          end
        endcase
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Outputs are registered from the next state so they line up with it.
    ready_d  = (state_d == StIdle);
    enable_d = (state_d == StRead) || (state_d == StWrite);
    write_d  = (state_d == StWrite);
    done_d   = (state_d == StDone);
    err_d    = (state_d == StDone) && (op == OP_RSV);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      re_acc_q <= '0;
      im_acc_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      wa_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      re_acc_q <= re_acc_d;
      im_acc_q <= im_acc_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      ra1_q    <= ra1_d;
      ra2_q    <= ra2_d;
      wa_q     <= wa_d;
      wdata_q  <= wdata_d;
    end
  end

  assign instr_ready       = ready_q;
  assign done              = done_q;
  assign err               = err_q;
  assign mem_enable        = enable_q;
  assign mem_write         = write_q;
  assign mem_read_address1 = ra1_q;
  assign mem_read_address2 = ra2_q;
  assign mem_write_address = wa_q;
  assign mem_in_data       = wdata_q;

endmodule

// File: tb/tb_complex_exec_unit.sv
// Self-checking bench: a behavioural 64x8 memory plus an arithmetic reference model of
// complex add/sub/mul with saturation, driven by directed and random instructions.
module tb_complex_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [19:0] instr = '0;
  logic        instr_ready, done, err, mem_enable, mem_write;
  logic [5:0]  mem_read_address1, mem_read_address2, mem_write_address;
  logic [7:0]  mem_in_data, mem_out_data1, mem_out_data2;

  always #5 clk = ~clk;

  complex_exec_unit #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .done(done),
    .err(err),
    .mem_enable(mem_enable),
    .mem_write(mem_write),
    .mem_read_address1(mem_read_address1),
    .mem_read_address2(mem_read_address2),
    .mem_write_address(mem_write_address),
    .mem_in_data(mem_in_data),
    .mem_out_data1(mem_out_data1),
    .mem_out_data2(mem_out_data2)
  );

  // Synchronous memory: read data valid the cycle after enable.
  logic [7:0] mem [64];
  logic [7:0] rd1 = '0, rd2 = '0;
  logic       pre_en = 1'b0;
  logic [5:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_enable) begin
      if (mem_write) mem[mem_write_address] <= mem_in_data;
      else begin
        rd1 <= mem[mem_read_address1];
        rd2 <= mem[mem_read_address2];
      end
    end
  end
  assign mem_out_data1 = rd1;
  assign mem_out_data2 = rd2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 7) ? 7 : ((v < -8) ? -8 : v);
  endfunction

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    int ar, ai, br, bi, re, im;
    logic [3:0] rn, in4;
    ar = int'($signed(a[7:4]));
    ai = int'($signed(a[3:0]));
    br = int'($signed(b[7:4]));
    bi = int'($signed(b[3:0]));
    if (op == 2'd0) begin
      re = ar + br; im = ai + bi;
    end else if (op == 2'd1) begin
      re = ar - br; im = ai - bi;
    end else begin
      re = ar * br - ai * bi; im = ar * bi + ai * br;
    end
    rn  = 4'(clamp(re));
    in4 = 4'(clamp(im));
    return {rn, in4};
  endfunction

  task automatic preload(input logic [5:0] addr, input logic [7:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!instr_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_ready"}, instr_ready, 1);
  endtask

  // Issue one instruction, keep junk valid asserted while busy, and check the whole retire.
  task automatic run(input logic [1:0] op, input logic [5:0] rs1, input logic [5:0] rs2,
                     input logic [5:0] rd, input string tag);
    logic [7:0] exp;
    int lat, cyc, writes;
    exp = model(op, ref_mem[rs1], ref_mem[rs2]);
    lat = (op == 2'd2) ? 8 : ((op == 2'd3) ? 3 : 5);
    wait_ready(tag);
    instr_valid = 1'b1;
    instr = {op, rs1, rs2, rd};
    @(posedge clk); #1;
    instr = 20'($urandom);
    check({tag, "_busy"}, instr_ready, 0);
    cyc = 1; writes = 0;
    while (!done && cyc < 30) begin
      if (mem_write) begin
        writes++;
        check({tag, "_waddr"}, mem_write_address, rd);
        check({tag, "_wdata"}, mem_in_data, exp);
      end
      @(posedge clk); #1; cyc++;
    end
    instr_valid = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_err"}, err, (op == 2'd3));
    check({tag, "_writes"}, writes, (op == 2'd3) ? 0 : 1);
    if (op != 2'd3) ref_mem[rd] = exp;
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_mem"}, mem[rd], ref_mem[rd]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) preload(6'(i), 8'($urandom));
    check("rst_ready", instr_ready, 1);
    check("rst_outs", {done, err, mem_enable, mem_write}, 0);
    check("rst_addr", {mem_read_address1, mem_read_address2, mem_write_address}, 0);
    check("rst_data", mem_in_data, 0);
    @(negedge clk); rst = 1'b1;

    preload(0, 8'h31); preload(1, 8'h23);
    run(2'd0, 0, 1, 2, "add_a");      check("add_a_k", mem[2], 8'h54);
    preload(3, 8'h93); preload(4, 8'h61);
    run(2'd0, 3, 4, 5, "add_b");      check("add_b_k", mem[5], 8'hF4);
    preload(6, 8'h70); preload(7, 8'h70);
    run(2'd0, 6, 7, 8, "add_sat");    check("add_sat_k", mem[8], 8'h70);
    preload(12, 8'hBE); preload(13, 8'h23);
    run(2'd1, 12, 13, 14, "sub_a");   check("sub_a_k", mem[14], 8'h9B);
    preload(9, 8'h80); preload(10, 8'h70);
    run(2'd1, 9, 10, 11, "sub_sat");  check("sub_sat_k", mem[11], 8'h80);
    preload(15, 8'h22); preload(16, 8'h21);
    run(2'd2, 15, 16, 17, "mul_a");   check("mul_a_k", mem[17], 8'h26);
    preload(18, 8'hD2); preload(19, 8'hE1);
    run(2'd2, 18, 19, 20, "mul_b");   check("mul_b_k", mem[20], 8'h49);
    run(2'd3, 21, 22, 23, "rsv");
    run(2'd0, 0, 1, 0, "alias");      check("alias_k", mem[0], 8'h54);

    // Abort a multiply in its third MUL cycle.
    preload(30, 8'h5A);
    wait_ready("abort");
    instr_valid = 1'b1; instr = {2'd2, 6'd18, 6'd19, 6'd30};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0; #1;
    check("abort_ready", instr_ready, 1);
    check("abort_outs", {done, err, mem_enable, mem_write}, 0);
    check("abort_addr", {mem_read_address1, mem_read_address2, mem_write_address}, 0);
    check("abort_data", mem_in_data, 0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_nowrite", mem[30], 8'h5A);
    check("abort_rel_ready", instr_ready, 1);
    run(2'd2, 15, 16, 31, "after_abort"); check("after_abort_k", mem[31], 8'h26);

    for (int k = 0; k < 150; k++) begin
      if (k % 4 == 0) preload(6'($urandom), 8'($urandom));
      run(2'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), "rnd");
    end
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
